// File: rtl/mem_read_buffer_if.sv
// Memory byte bus in, assembled-word valid/ready out; master = memory/consumer side, slave = buffer.
interface mem_read_buffer_if #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32
);
  logic [DATA_W-1:0] mdat_in;
  logic              mrd;
  logic              fetch;
  logic [WORD_W-1:0] word_data;
  logic              word_is_instr;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output mdat_in, mrd, fetch, word_ready,
    input  word_data, word_is_instr, word_valid
  );

  modport slave (
    input  mdat_in, mrd, fetch, word_ready,
    output word_data, word_is_instr, word_valid
  );
endinterface

// File: rtl/mem_read_buffer.sv
// Packs strobed memory bytes into typed words and queues them; word_valid one cycle after the last byte.
// No backpressure to memory: a completed word meeting a full FIFO (without a same-cycle pop) is dropped and flagged.
module mem_read_buffer #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_read_buffer_if.slave bus,
  input  logic             abort,
  input  logic             err_clr,
  output logic             full,
  output logic             overflow,
  output logic             proto_err
);
  localparam int WORD_W = DATA_W * WORD_BYTES;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;

  typedef struct packed {
    logic              instr;
    logic [WORD_W-1:0] data;
  } word_t;

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] asm_q;
  logic              asm_instr;
  word_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              beat;
  logic              conflict;
  logic              type_switch;
  logic [CNT_W-1:0]  lane;
  logic              last;
  logic              word_instr;
  logic [WORD_W-1:0] asm_next;
  logic              empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  assign beat        = bus.mrd ^ bus.fetch;
  assign conflict    = bus.mrd & bus.fetch;
  assign type_switch = beat && (cnt != '0) && (bus.fetch != asm_instr);
  // A type switch restarts assembly, so the new byte lands in lane 0.
  assign lane        = type_switch ? '0 : cnt;
  assign last        = beat && (lane == CNT_W'(WORD_BYTES - 1));
  assign word_instr  = ((cnt == '0) || type_switch) ? bus.fetch : asm_instr;

  always_comb begin
    asm_next = type_switch ? '0 : asm_q;
    asm_next[int'(lane)*DATA_W +: DATA_W] = bus.mdat_in;
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && bus.word_ready;
  // A pop in the same cycle frees the slot the completing word needs.
  assign push_ok   = last && (!fifo_full || pop);
  assign drop      = last && fifo_full && !pop;

  assign full              = fifo_full;
  assign bus.word_valid    = !empty;
  assign bus.word_data     = empty ? '0 : mem[rd_ptr[AW-1:0]].data;
  assign bus.word_is_instr = empty ? 1'b0 : mem[rd_ptr[AW-1:0]].instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      asm_q     <= '0;
      asm_instr <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow  <= (!abort && drop) || (overflow && !err_clr);
      proto_err <= (!abort && (conflict || type_switch)) || (proto_err && !err_clr);
      if (abort) begin
        cnt       <= '0;
        asm_q     <= '0;
        asm_instr <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        if (beat) begin
          cnt       <= last ? '0 : lane + 1'b1;
          asm_q     <= last ? '0 : asm_next;
          asm_instr <= word_instr;
        end
        if (push_ok) begin
          mem[wr_ptr[AW-1:0]] <= '{instr: word_instr, data: asm_next};
          wr_ptr              <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_read_buffer.sv
// Bench for mem_read_buffer: vector table, directed corner sequences, then random traffic against a queue model.
module tb_mem_read_buffer;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic err_clr = 1'b0;
  logic full, overflow, proto_err;

  mem_read_buffer_if #(.DATA_W(8), .WORD_W(32)) bus ();

  mem_read_buffer #(.DATA_W(8), .WORD_BYTES(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .abort(abort), .err_clr(err_clr),
    .full(full), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        i;
  } mw_t;
  mw_t        mq[$];
  logic [7:0] part[$];
  logic       part_instr = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_perr = 1'b0;

  typedef struct {
    logic m, f; logic [7:0] d; logic ab, rdy, clr;
    logic vld; logic [31:0] data; logic instr, full, ovf, perr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic m, f, logic [7:0] d, logic ab, rdy, clr,
                              logic vld, logic [31:0] data, logic instr, full, ovf, perr);
    vec_t v;
    v.m = m; v.f = f; v.d = d; v.ab = ab; v.rdy = rdy; v.clr = clr;
    v.vld = vld; v.data = data; v.instr = instr; v.full = full; v.ovf = ovf; v.perr = perr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic m, f, logic [7:0] d, logic ab, rdy, clr);
    bus.mrd = m; bus.fetch = f; bus.mdat_in = d;
    abort = ab; bus.word_ready = rdy; err_clr = clr;
  endtask

  task automatic model_clear();
    mq.delete(); part.delete(); part_instr = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  // Reference: bytes collect in a list; four of one type make a word for a bounded queue.
  task automatic model_step(logic m, f, logic [7:0] d, logic ab, rdy, clr);
    logic pe, oe, pop;
    mw_t w;
    pe = 1'b0; oe = 1'b0;
    pop = (mq.size() > 0) && rdy;
    if (ab) begin
      mq.delete(); part.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m && f) pe = 1'b1;
      else if (m || f) begin
        if (part.size() > 0 && part_instr != f) begin pe = 1'b1; part.delete(); end
        if (part.size() == 0) part_instr = f;
        part.push_back(d);
        if (part.size() == 4) begin
          w.d = {part[3], part[2], part[1], part[0]};
          w.i = part_instr;
          if (mq.size() < DEPTH) mq.push_back(w); else oe = 1'b1;
          part.delete();
        end
      end
    end
    m_perr = pe | (m_perr & !clr);
    m_ovf  = oe | (m_ovf & !clr);
  endtask

  task automatic model_cmp(string tag);
    chk({tag, ".valid"}, 32'(bus.word_valid), 32'(mq.size() > 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".perr"}, 32'(proto_err), 32'(m_perr));
    if (mq.size() > 0) begin
      chk({tag, ".data"}, bus.word_data, mq[0].d);
      chk({tag, ".instr"}, 32'(bus.word_is_instr), 32'(mq[0].i));
    end
  endtask

  task automatic step(logic m, f, logic [7:0] d, logic ab, rdy, clr);
    drive(m, f, d, ab, rdy, clr);
    model_step(m, f, d, ab, rdy, clr);
    @(posedge clk); #1;
    model_cmp("model");
  endtask

  task automatic send_word(logic f, logic [31:0] w, logic rdy);
    for (int b = 0; b < 4; b++) step(!f, f, w[b*8 +: 8], 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    drive(0, 0, 8'h00, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    drive(0, 0, 8'h00, 0, 0, 0);
    #2;
    chk("rst.valid", 32'(bus.word_valid), 0);
    chk("rst.data", bus.word_data, 0);
    chk("rst.instr", 32'(bus.word_is_instr), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.perr", 32'(proto_err), 0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // m f dat ab rdy clr | vld data instr full ovf perr
    tbl.push_back(mk(0,1,8'h13,0,1,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h05,0,1,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h10,0,1,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h00,0,1,0, 1,32'h00100513,1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0,1,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(1,0,8'hEE,0,1,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(1,0,8'hFF,0,1,0, 0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,8'h01,0,1,0, 0,32'h0,0,0,0,1));
    tbl.push_back(mk(0,1,8'h02,0,1,0, 0,32'h0,0,0,0,1));
    tbl.push_back(mk(0,1,8'h03,0,1,0, 0,32'h0,0,0,0,1));
    tbl.push_back(mk(0,1,8'h04,0,1,0, 1,32'h04030201,1,0,0,1));
    tbl.push_back(mk(1,1,8'h55,0,0,0, 1,32'h04030201,1,0,0,1));
    tbl.push_back(mk(0,1,8'hAA,0,0,0, 1,32'h04030201,1,0,0,1));
    tbl.push_back(mk(0,1,8'hBB,0,0,0, 1,32'h04030201,1,0,0,1));
    tbl.push_back(mk(0,1,8'hCC,0,0,0, 1,32'h04030201,1,0,0,1));
    tbl.push_back(mk(0,1,8'hDD,0,0,0, 1,32'h04030201,1,1,0,1));
    tbl.push_back(mk(0,0,8'h00,0,1,0, 1,32'hDDCCBBAA,1,0,0,1));
    tbl.push_back(mk(0,0,8'h00,0,1,1, 0,32'h0,0,0,0,0));

    foreach (tbl[k]) begin
      drive(tbl[k].m, tbl[k].f, tbl[k].d, tbl[k].ab, tbl[k].rdy, tbl[k].clr);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.valid", k), 32'(bus.word_valid), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d.full", k), 32'(full), 32'(tbl[k].full));
      chk($sformatf("tbl%0d.ovf", k), 32'(overflow), 32'(tbl[k].ovf));
      chk($sformatf("tbl%0d.perr", k), 32'(proto_err), 32'(tbl[k].perr));
      if (tbl[k].vld) begin
        chk($sformatf("tbl%0d.data", k), bus.word_data, tbl[k].data);
        chk($sformatf("tbl%0d.instr", k), 32'(bus.word_is_instr), 32'(tbl[k].instr));
      end
    end

    // Overflow on the third word while stalled.
    do_reset();
    send_word(0, 32'h11223344, 0);
    send_word(0, 32'hAABBCCDD, 0);
    chk("ovf.full_after_2", 32'(full), 1);
    send_word(0, 32'h01020304, 0);
    chk("ovf.flag", 32'(overflow), 1);
    chk("ovf.head0", bus.word_data, 32'h11223344);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("ovf.head1", bus.word_data, 32'hAABBCCDD);
    chk("ovf.instr1", 32'(bus.word_is_instr), 0);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("ovf.drained", 32'(bus.word_valid), 0);

    // Completion while full, with a pop in the same cycle.
    step(0, 0, 8'h00, 0, 0, 1);
    send_word(0, 32'hCAFE0001, 0);
    send_word(0, 32'hCAFE0002, 0);
    step(1, 0, 8'h88, 0, 0, 0);
    step(1, 0, 8'h77, 0, 0, 0);
    step(1, 0, 8'h66, 0, 0, 0);
    step(1, 0, 8'h55, 0, 1, 0);
    chk("pp.no_ovf", 32'(overflow), 0);
    chk("pp.full", 32'(full), 1);
    chk("pp.head_old", bus.word_data, 32'hCAFE0002);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("pp.head_new", bus.word_data, 32'h55667788);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("pp.empty", 32'(bus.word_valid), 0);

    // Abort with a partial word, a queued word and a same-cycle beat.
    send_word(1, 32'h0BADF00D, 0);
    step(0, 1, 8'h01, 0, 0, 0);
    step(0, 1, 8'h02, 0, 0, 0);
    step(0, 1, 8'h03, 1, 0, 0);
    chk("abort.valid", 32'(bus.word_valid), 0);
    chk("abort.full", 32'(full), 0);
    send_word(0, 32'h87654321, 0);
    chk("abort.clean", bus.word_data, 32'h87654321);
    chk("abort.clean_perr", 32'(proto_err), 0);

    // Asynchronous reset mid-word with one entry and a sticky flag.
    step(0, 1, 8'hA1, 0, 0, 0);
    step(1, 1, 8'hA2, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.word_valid), 0);
    chk("arst.data", bus.word_data, 0);
    chk("arst.perr", 32'(proto_err), 0);
    chk("arst.full", 32'(full), 0);
    model_clear();
    drive(0, 0, 8'h00, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(0, 32'hFEEDBEEF, 0);
    chk("arst.fresh", bus.word_data, 32'hFEEDBEEF);

    // Sticky flags: set both, then clear; an event alongside clear wins.
    send_word(0, 32'h00000001, 0);
    send_word(0, 32'h00000002, 0);
    step(1, 1, 8'h00, 0, 0, 0);
    chk("clr.ovf_set", 32'(overflow), 1);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("clr.ovf", 32'(overflow), 0);
    chk("clr.perr", 32'(proto_err), 0);
    step(1, 1, 8'h00, 0, 0, 1);
    chk("clr.event_wins", 32'(proto_err), 1);

    // Random traffic against the queue model.
    do_reset();
    begin
      logic rt;
      rt = 1'b0;
      for (int n = 0; n < 800; n++) begin
        logic m, f, ab, rdy, clr;
        int r;
        if ($urandom_range(0, 9) == 0) rt = !rt;
        r = int'($urandom_range(0, 99));
        m = 1'b0; f = 1'b0;
        if (r < 3) begin m = 1'b1; f = 1'b1; end
        else if (r < 70) begin m = !rt; f = rt; end
        ab  = ($urandom_range(0, 49) == 0);
        clr = ($urandom_range(0, 19) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        step(m, f, 8'($urandom), ab, rdy, clr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
